// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, ALU selectors and the
// packed control word produced by the decoder and carried by the output stage.
package mips_pkg;

    localparam int ALU_TYPE_W = 3;
    localparam int ALU_OP_W   = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    // Zero is reserved for "no ALU unit" so an all-zero word is a NOP.
    localparam logic [ALU_TYPE_W-1:0] ALU_NONE    = 3'd0;
    localparam logic [ALU_TYPE_W-1:0] ALU_LOGIC   = 3'd1;
    localparam logic [ALU_TYPE_W-1:0] ALU_SHIFT   = 3'd2;
    localparam logic [ALU_TYPE_W-1:0] ALU_ADD_SUB = 3'd3;
    localparam logic [ALU_TYPE_W-1:0] ALU_COMP    = 3'd4;
    localparam logic [ALU_TYPE_W-1:0] ALU_MUL_DIV = 3'd5;
    localparam logic [ALU_TYPE_W-1:0] ALU_OTHER   = 3'd6;

    typedef enum logic [ALU_OP_W-1:0] {
        AOP_NONE, AOP_AND, AOP_OR, AOP_XOR, AOP_NOR,
        AOP_SLL, AOP_SRL, AOP_SRA,
        AOP_ADD, AOP_ADDU, AOP_SUB, AOP_SUBU,
        AOP_SLT, AOP_SLTU,
        AOP_MULT, AOP_MULTU, AOP_DIV, AOP_DIVU, AOP_MFHI, AOP_MFLO,
        AOP_LUI, AOP_LINK
    } alu_op_e;

    localparam logic SRC_RS    = 1'b0;
    localparam logic SRC_SHAMT = 1'b1;
    localparam logic SRC_RT    = 1'b0;
    localparam logic SRC_IMM   = 1'b1;

    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef struct packed {
        logic                  write_reg;
        logic                  mem_or_alu;
        logic                  write_mem;
        logic                  read_mem;
        logic [ALU_TYPE_W-1:0] alu_type;
        alu_op_e               alu_op;
        logic                  alu_src_a;
        logic                  alu_src_b;
        logic                  imm_signed;
        logic [4:0]            dest_reg;
        logic                  is_jal;
        logic                  is_jr;
        logic                  is_branch;
        logic [1:0]            mem_size;
        logic                  mem_unsigned;
        logic                  illegal;
    } ctrl_t;

endpackage

// File: rtl/inst_decode_comb.sv
// Pure combinational MIPS decoder: instruction word in, fully defined control word out.
// Unrecognised encodings produce an all-zero word with only illegal set.
module inst_decode_comb
    import mips_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_fields;

    assign opcode        = inst[31:26];
    assign funct         = inst[5:0];
    assign rt            = inst[20:16];
    assign rd            = inst[15:11];
    assign unused_fields = ^{inst[25:21], inst[10:6]};

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.dest_reg  = rd;
                ctrl.write_reg = 1'b1;
                case (funct)
                    FN_SLL:   begin ctrl.alu_type = ALU_SHIFT; ctrl.alu_op = AOP_SLL; ctrl.alu_src_a = SRC_SHAMT; end
                    FN_SRL:   begin ctrl.alu_type = ALU_SHIFT; ctrl.alu_op = AOP_SRL; ctrl.alu_src_a = SRC_SHAMT; end
                    FN_SRA:   begin ctrl.alu_type = ALU_SHIFT; ctrl.alu_op = AOP_SRA; ctrl.alu_src_a = SRC_SHAMT; end
                    FN_SLLV:  begin ctrl.alu_type = ALU_SHIFT; ctrl.alu_op = AOP_SLL; end
                    FN_SRLV:  begin ctrl.alu_type = ALU_SHIFT; ctrl.alu_op = AOP_SRL; end
                    FN_SRAV:  begin ctrl.alu_type = ALU_SHIFT; ctrl.alu_op = AOP_SRA; end
                    FN_JR:    begin ctrl.write_reg = 1'b0; ctrl.is_jr = 1'b1; end
                    FN_MFHI:  begin ctrl.alu_type = ALU_MUL_DIV; ctrl.alu_op = AOP_MFHI; end
                    FN_MFLO:  begin ctrl.alu_type = ALU_MUL_DIV; ctrl.alu_op = AOP_MFLO; end
                    // Multiply/divide results go to HI/LO, never the register file.
                    FN_MULT:  begin ctrl.write_reg = 1'b0; ctrl.alu_type = ALU_MUL_DIV; ctrl.alu_op = AOP_MULT;  end
                    FN_MULTU: begin ctrl.write_reg = 1'b0; ctrl.alu_type = ALU_MUL_DIV; ctrl.alu_op = AOP_MULTU; end
                    FN_DIV:   begin ctrl.write_reg = 1'b0; ctrl.alu_type = ALU_MUL_DIV; ctrl.alu_op = AOP_DIV;   end
                    FN_DIVU:  begin ctrl.write_reg = 1'b0; ctrl.alu_type = ALU_MUL_DIV; ctrl.alu_op = AOP_DIVU;  end
                    FN_ADD:   begin ctrl.alu_type = ALU_ADD_SUB; ctrl.alu_op = AOP_ADD;  end
                    FN_ADDU:  begin ctrl.alu_type = ALU_ADD_SUB; ctrl.alu_op = AOP_ADDU; end
                    FN_SUB:   begin ctrl.alu_type = ALU_ADD_SUB; ctrl.alu_op = AOP_SUB;  end
                    FN_SUBU:  begin ctrl.alu_type = ALU_ADD_SUB; ctrl.alu_op = AOP_SUBU; end
                    FN_AND:   begin ctrl.alu_type = ALU_LOGIC; ctrl.alu_op = AOP_AND; end
                    FN_OR:    begin ctrl.alu_type = ALU_LOGIC; ctrl.alu_op = AOP_OR;  end
                    FN_XOR:   begin ctrl.alu_type = ALU_LOGIC; ctrl.alu_op = AOP_XOR; end
                    FN_NOR:   begin ctrl.alu_type = ALU_LOGIC; ctrl.alu_op = AOP_NOR; end
                    FN_SLT:   begin ctrl.alu_type = ALU_COMP; ctrl.alu_op = AOP_SLT;  end
                    FN_SLTU:  begin ctrl.alu_type = ALU_COMP; ctrl.alu_op = AOP_SLTU; end
                    default:  ctrl.illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                ctrl.dest_reg  = 5'd31;
                ctrl.write_reg = 1'b1;
                ctrl.is_jal    = 1'b1;
                ctrl.alu_type  = ALU_OTHER;
                ctrl.alu_op    = AOP_LINK;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.dest_reg   = rt;
                ctrl.is_branch  = 1'b1;
                ctrl.imm_signed = 1'b1;
                ctrl.alu_type   = ALU_ADD_SUB;
                ctrl.alu_op     = AOP_SUB;
            end
            default: begin
                // Immediate forms: start from an address-style signed add.
                ctrl.dest_reg   = rt;
                ctrl.write_reg  = 1'b1;
                ctrl.alu_src_b  = SRC_IMM;
                ctrl.imm_signed = 1'b1;
                ctrl.alu_type   = ALU_ADD_SUB;
                ctrl.alu_op     = AOP_ADD;
                case (opcode)
                    OP_ADDI:  ;
                    OP_ADDIU: ctrl.alu_op = AOP_ADDU;
                    OP_SLTI:  begin ctrl.alu_type = ALU_COMP; ctrl.alu_op = AOP_SLT; end
                    OP_ANDI:  begin ctrl.alu_type = ALU_LOGIC; ctrl.alu_op = AOP_AND; ctrl.imm_signed = 1'b0; end
                    OP_ORI:   begin ctrl.alu_type = ALU_LOGIC; ctrl.alu_op = AOP_OR;  ctrl.imm_signed = 1'b0; end
                    OP_XORI:  begin ctrl.alu_type = ALU_LOGIC; ctrl.alu_op = AOP_XOR; ctrl.imm_signed = 1'b0; end
                    OP_LUI:   begin ctrl.alu_type = ALU_OTHER; ctrl.alu_op = AOP_LUI; ctrl.imm_signed = 1'b0; end
                    OP_LB:    begin ctrl.read_mem = 1'b1; ctrl.mem_or_alu = SEL_MEM; ctrl.mem_size = MEM_BYTE; end
                    OP_LH:    begin ctrl.read_mem = 1'b1; ctrl.mem_or_alu = SEL_MEM; ctrl.mem_size = MEM_HALF; end
                    OP_LW:    begin ctrl.read_mem = 1'b1; ctrl.mem_or_alu = SEL_MEM; ctrl.mem_size = MEM_WORD; end
                    OP_LBU:   begin ctrl.read_mem = 1'b1; ctrl.mem_or_alu = SEL_MEM; ctrl.mem_size = MEM_BYTE; ctrl.mem_unsigned = 1'b1; end
                    OP_LHU:   begin ctrl.read_mem = 1'b1; ctrl.mem_or_alu = SEL_MEM; ctrl.mem_size = MEM_HALF; ctrl.mem_unsigned = 1'b1; end
                    OP_SB:    begin ctrl.write_reg = 1'b0; ctrl.write_mem = 1'b1; ctrl.mem_size = MEM_BYTE; end
                    OP_SH:    begin ctrl.write_reg = 1'b0; ctrl.write_mem = 1'b1; ctrl.mem_size = MEM_HALF; end
                    OP_SW:    begin ctrl.write_reg = 1'b0; ctrl.write_mem = 1'b1; ctrl.mem_size = MEM_WORD; end
                    default:  ctrl.illegal = 1'b1;
                endcase
            end
        endcase

        if (ctrl.illegal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
        // $0 is hard-wired, so a write to it is a no-op.
        if (ctrl.dest_reg == 5'd0) begin
            ctrl.write_reg = 1'b0;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Fetch-side FIFO feeding a registered decode stage; the FIFO head is decoded
// combinationally and captured with its instruction word and PC tag.
module decode_queue
    import mips_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INST_W-1:0]       in_inst,
    input  logic [PC_W-1:0]         in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INST_W-1:0]       out_inst,
    output logic [PC_W-1:0]         out_pc,
    output logic                    write_reg,
    output logic                    mem_or_alu,
    output logic                    write_mem,
    output logic                    read_mem,
    output logic [ALU_TYPE_W-1:0]   alu_type,
    output logic [ALU_OP_W-1:0]     alu_op,
    output logic                    alu_src_a,
    output logic                    alu_src_b,
    output logic                    imm_signed,
    output logic [4:0]              dest_reg,
    output logic                    is_jal,
    output logic                    is_jr,
    output logic                    is_branch,
    output logic [1:0]              mem_size,
    output logic                    mem_unsigned,
    output logic                    illegal,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              out_valid_reg;
    ctrl_t             ctrl_reg;
    logic [INST_W-1:0] inst_reg;
    logic [PC_W-1:0]   pc_reg;

    ctrl_t             head_ctrl;
    logic [INST_W-1:0] head_inst;
    logic              full;
    logic              empty;
    logic              stage_free;
    logic              push;
    logic              pop;

    assign head_inst  = inst_mem[rd_ptr_reg];
    assign full       = (count_reg == FULL_COUNT);
    assign empty      = (count_reg == '0);
    assign stage_free = !out_valid_reg || out_ready;
    // No pass-through: a full FIFO refuses input even when the head is leaving.
    assign in_ready   = !full && !flush && !rst;
    assign push       = in_valid && in_ready;
    assign pop        = stage_free && !empty && !flush && !rst;

    inst_decode_comb u_decode (
        .inst (head_inst[31:0]),
        .ctrl (head_ctrl)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= in_inst;
            pc_mem[wr_ptr_reg]   <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            ctrl_reg      <= '0;
            inst_reg      <= '0;
            pc_reg        <= '0;
        end else if (flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                ctrl_reg      <= head_ctrl;
                inst_reg      <= head_inst;
                pc_reg        <= pc_mem[rd_ptr_reg];
                out_valid_reg <= 1'b1;
            end else if (stage_free) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_inst     = inst_reg;
    assign out_pc       = pc_reg;
    assign occupancy    = count_reg;
    assign write_reg    = ctrl_reg.write_reg;
    assign mem_or_alu   = ctrl_reg.mem_or_alu;
    assign write_mem    = ctrl_reg.write_mem;
    assign read_mem     = ctrl_reg.read_mem;
    assign alu_type     = ctrl_reg.alu_type;
    assign alu_op       = ctrl_reg.alu_op;
    assign alu_src_a    = ctrl_reg.alu_src_a;
    assign alu_src_b    = ctrl_reg.alu_src_b;
    assign imm_signed   = ctrl_reg.imm_signed;
    assign dest_reg     = ctrl_reg.dest_reg;
    assign is_jal       = ctrl_reg.is_jal;
    assign is_jr        = ctrl_reg.is_jr;
    assign is_branch    = ctrl_reg.is_branch;
    assign mem_size     = ctrl_reg.mem_size;
    assign mem_unsigned = ctrl_reg.mem_unsigned;
    assign illegal      = ctrl_reg.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Randomised and directed bench for decode_queue, checked against a queue-based
// model and a mnemonic-driven reference decoder.
module tb_decode_queue;
    import mips_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_inst, out_pc;
    logic        write_reg, mem_or_alu, write_mem, read_mem;
    logic [2:0]  alu_type;
    logic [4:0]  alu_op;
    logic        alu_src_a, alu_src_b, imm_signed;
    logic [4:0]  dest_reg;
    logic        is_jal, is_jr, is_branch;
    logic [1:0]  mem_size;
    logic        mem_unsigned, illegal;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    ent_t        m_fifo[$];
    logic        m_valid = 1'b0;
    logic        m_zero  = 1'b0;
    logic        m_known = 1'b0;
    logic [31:0] m_inst, m_pc;

    logic [5:0] fn_list [23] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h10,
                                 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h20, 6'h21, 6'h22,
                                 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    logic [5:0] op_list [18] = '{6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d,
                                 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28,
                                 6'h29, 6'h2b};

    always #5 clk = ~clk;

    decode_queue #(.INST_W(32), .PC_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .write_reg(write_reg), .mem_or_alu(mem_or_alu), .write_mem(write_mem), .read_mem(read_mem),
        .alu_type(alu_type), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_signed(imm_signed), .dest_reg(dest_reg), .is_jal(is_jal), .is_jr(is_jr),
        .is_branch(is_branch), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .illegal(illegal), .occupancy(occupancy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic string mnem(input logic [31:0] i);
        case (i[31:26])
            6'h00: case (i[5:0])
                6'h00: return "sll";   6'h02: return "srl";   6'h03: return "sra";
                6'h04: return "sllv";  6'h06: return "srlv";  6'h07: return "srav";
                6'h08: return "jr";    6'h10: return "mfhi";  6'h12: return "mflo";
                6'h18: return "mult";  6'h19: return "multu"; 6'h1a: return "div";
                6'h1b: return "divu";  6'h20: return "add";   6'h21: return "addu";
                6'h22: return "sub";   6'h23: return "subu";  6'h24: return "and";
                6'h25: return "or";    6'h26: return "xor";   6'h27: return "nor";
                6'h2a: return "slt";   6'h2b: return "sltu";
                default: return "";
            endcase
            6'h03: return "jal";  6'h04: return "beq";  6'h05: return "bne";
            6'h08: return "addi"; 6'h09: return "addiu"; 6'h0a: return "slti";
            6'h0c: return "andi"; 6'h0d: return "ori";  6'h0e: return "xori";
            6'h0f: return "lui";  6'h20: return "lb";   6'h21: return "lh";
            6'h23: return "lw";   6'h24: return "lbu";  6'h25: return "lhu";
            6'h28: return "sb";   6'h29: return "sh";   6'h2b: return "sw";
            default: return "";
        endcase
    endfunction

    // Expected control word, same bit order as dut_ctrl below.
    function automatic logic [26:0] ref_ctrl(input logic [31:0] i);
        string m = mnem(i);
        logic wr = 0, moa = 0, wm = 0, rm = 0, sa = 0, sb = 0, ims = 0;
        logic jal = 0, jr = 0, br = 0, mu = 0, ill = 0, rtype, muldiv;
        logic [2:0] ty = 0;
        logic [4:0] op = 0, dst = 0;
        logic [1:0] ms = 0;
        if (m == "") begin
            ill = 1;
        end else begin
            rtype  = (i[31:26] == 6'h00);
            rm     = (m == "lb" || m == "lh" || m == "lw" || m == "lbu" || m == "lhu");
            wm     = (m == "sb" || m == "sh" || m == "sw");
            moa    = rm;
            jal    = (m == "jal");
            jr     = (m == "jr");
            br     = (m == "beq" || m == "bne");
            muldiv = (m == "mult" || m == "multu" || m == "div" || m == "divu");
            dst    = jal ? 5'd31 : (rtype ? i[15:11] : i[20:16]);
            wr     = !(jr || muldiv || br || wm) && (dst != 0);
            sa     = (m == "sll" || m == "srl" || m == "sra");
            sb     = !rtype && !jal && !br;
            ims    = rm || wm || br || m == "addi" || m == "addiu" || m == "slti";
            ms     = (m == "lh" || m == "lhu" || m == "sh") ? 2'd1 :
                     (m == "lw" || m == "sw") ? 2'd2 : 2'd0;
            mu     = (m == "lbu" || m == "lhu");
            case (m)
                "sll", "sllv": begin ty = ALU_SHIFT; op = AOP_SLL; end
                "srl", "srlv": begin ty = ALU_SHIFT; op = AOP_SRL; end
                "sra", "srav": begin ty = ALU_SHIFT; op = AOP_SRA; end
                "and", "andi": begin ty = ALU_LOGIC; op = AOP_AND; end
                "or", "ori":   begin ty = ALU_LOGIC; op = AOP_OR;  end
                "xor", "xori": begin ty = ALU_LOGIC; op = AOP_XOR; end
                "nor":         begin ty = ALU_LOGIC; op = AOP_NOR; end
                "add", "addi", "lb", "lh", "lw", "lbu", "lhu", "sb", "sh", "sw":
                               begin ty = ALU_ADD_SUB; op = AOP_ADD; end
                "addu", "addiu": begin ty = ALU_ADD_SUB; op = AOP_ADDU; end
                "sub", "beq", "bne": begin ty = ALU_ADD_SUB; op = AOP_SUB; end
                "subu":        begin ty = ALU_ADD_SUB; op = AOP_SUBU; end
                "slt", "slti": begin ty = ALU_COMP; op = AOP_SLT;  end
                "sltu":        begin ty = ALU_COMP; op = AOP_SLTU; end
                "mult":        begin ty = ALU_MUL_DIV; op = AOP_MULT;  end
                "multu":       begin ty = ALU_MUL_DIV; op = AOP_MULTU; end
                "div":         begin ty = ALU_MUL_DIV; op = AOP_DIV;   end
                "divu":        begin ty = ALU_MUL_DIV; op = AOP_DIVU;  end
                "mfhi":        begin ty = ALU_MUL_DIV; op = AOP_MFHI;  end
                "mflo":        begin ty = ALU_MUL_DIV; op = AOP_MFLO;  end
                "lui":         begin ty = ALU_OTHER; op = AOP_LUI;  end
                "jal":         begin ty = ALU_OTHER; op = AOP_LINK; end
                default:       begin ty = 0; op = 0; end
            endcase
        end
        return {wr, moa, wm, rm, ty, op, sa, sb, ims, dst, jal, jr, br, ms, mu, ill};
    endfunction

    function automatic logic [26:0] dut_ctrl();
        return {write_reg, mem_or_alu, write_mem, read_mem, alu_type, alu_op, alu_src_a,
                alu_src_b, imm_signed, dest_reg, is_jal, is_jr, is_branch, mem_size,
                mem_unsigned, illegal};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] x = $urandom;
        int sel = $urandom_range(0, 9);
        if (sel < 4) begin
            x[31:26] = 6'h00;
            x[5:0]   = fn_list[$urandom_range(0, 22)];
        end else if (sel < 8) begin
            x[31:26] = op_list[$urandom_range(0, 17)];
        end
        if ($urandom_range(0, 7) == 0) x[15:11] = 5'd0;
        if ($urandom_range(0, 7) == 0) x[20:16] = 5'd0;
        return x;
    endfunction

    // One clock: drive at the falling edge, check, clock, advance the model.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] inst, input logic [31:0] pc, input logic ordy);
        logic acc;
        rst = r; flush = f; in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy;
        #1;
        if (r || m_known)
            check("in_ready", 64'(in_ready), 64'(!r && !f && m_fifo.size() < DEPTH));
        if (m_known) begin
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("occupancy", 64'(occupancy), 64'(m_fifo.size()));
            if (m_valid) begin
                check("out_inst", 64'(out_inst), 64'(m_inst));
                check("out_pc", 64'(out_pc), 64'(m_pc));
                check("ctrl", 64'(dut_ctrl()), 64'(ref_ctrl(m_inst)));
            end
            if (m_zero) begin
                check("zero_inst", 64'(out_inst), 64'd0);
                check("zero_pc", 64'(out_pc), 64'd0);
                check("zero_ctrl", 64'(dut_ctrl()), 64'd0);
            end
        end
        @(posedge clk);
        if (r) begin
            m_fifo.delete(); m_valid = 0; m_zero = 1; m_known = 1;
        end else if (f) begin
            m_fifo.delete(); m_valid = 0;
        end else if (m_known) begin
            acc = iv && (m_fifo.size() < DEPTH);
            if (!m_valid || ordy) begin
                if (m_valid) $display("consume pc=%h inst=%h", m_pc, m_inst);
                if (m_fifo.size() > 0) begin
                    m_inst = m_fifo[0].inst; m_pc = m_fifo[0].pc;
                    void'(m_fifo.pop_front());
                    m_valid = 1; m_zero = 0;
                end else begin
                    m_valid = 0;
                end
            end
            if (acc) m_fifo.push_back('{inst, pc});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int k = 0; k < n; k++) step(0, 0, 0, 32'h0, 32'h0, ordy);
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0;
        @(negedge clk);

        // Reset held two cycles, then release.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(1, 1);

        // addi $1,$0,5
        step(0, 0, 1, 32'h20010005, 32'h100, 1);
        idle(1, 1);
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_wr", 64'(write_reg), 64'd1);
        check("addi_type", 64'(alu_type), 64'(ALU_ADD_SUB));
        check("addi_op", 64'(alu_op), 64'(AOP_ADD));
        check("addi_srcb", 64'(alu_src_b), 64'(SRC_IMM));
        check("addi_imms", 64'(imm_signed), 64'd1);
        check("addi_dest", 64'(dest_reg), 64'd1);
        check("addi_ill", 64'(illegal), 64'd0);
        idle(2, 1);

        // Backpressure: six pushes against a stalled consumer.
        for (int k = 0; k < 6; k++) step(0, 0, 1, 32'h00221820 + 32'(k << 11), 32'h200 + 32'(k * 4), 0);
        check("bp_occ", 64'(occupancy), 64'd4);
        check("bp_head", 64'(out_pc), 64'h200);
        check("bp_ready", 64'(in_ready), 64'd0);
        idle(7, 1);

        // Flush with three queued and one presented on the flush cycle.
        for (int k = 0; k < 3; k++) step(0, 0, 1, 32'h01094020, 32'h300 + 32'(k * 4), 0);
        step(0, 1, 1, 32'h3c0fdead, 32'h3ff, 0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_occ", 64'(occupancy), 64'd0);
        idle(3, 1);

        step(0, 0, 1, 32'hFC000000, 32'h400, 1);
        idle(1, 1);
        check("ill_flag", 64'(illegal), 64'd1);
        check("ill_strobes", 64'({write_reg, write_mem, read_mem}), 64'd0);
        step(0, 0, 1, 32'h00000000, 32'h404, 1);
        idle(1, 1);
        check("sll0_wr", 64'(write_reg), 64'd0);
        check("sll0_ill", 64'(illegal), 64'd0);
        step(0, 0, 1, 32'h0C000010, 32'h408, 1);
        idle(1, 1);
        check("jal_flag", 64'(is_jal), 64'd1);
        check("jal_wr", 64'(write_reg), 64'd1);
        check("jal_dest", 64'(dest_reg), 64'd31);
        step(0, 0, 1, 32'h94220004, 32'h40c, 1);
        idle(1, 1);
        check("lhu_rd", 64'(read_mem), 64'd1);
        check("lhu_moa", 64'(mem_or_alu), 64'(SEL_MEM));
        check("lhu_size", 64'(mem_size), 64'(MEM_HALF));
        check("lhu_uns", 64'(mem_unsigned), 64'd1);
        check("lhu_dest", 64'(dest_reg), 64'd2);
        check("lhu_imms", 64'(imm_signed), 64'd1);
        idle(2, 1);

        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 3) != 0, rand_inst(), $urandom,
                 $urandom_range(0, 2) != 0);
        end
        idle(8, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
